// File: rtl/m_param_multiword_cache_pkg.sv
// ============================================================================
// Module  : m_param_multiword_cache_pkg
// Brief   : Shared state encoding, derived address-field widths and helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package m_param_multiword_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

    localparam int DATA_W = 32;

    function automatic int calc_off_w(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int calc_idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int lines, input int words);
        return addr_w - calc_idx_w(lines) - calc_off_w(words);
    endfunction

    // Event counters stick at all-ones rather than wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_cache_line_ram.sv
// ============================================================================
// Module  : m_cache_line_ram
// Brief   : Tag and data storage; one asynchronous read port, per-word writes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module m_cache_line_ram
    import m_param_multiword_cache_pkg::*;
#(
    parameter int LINES = 32,
    parameter int WORDS = 2,
    parameter int TAG_W = 24,
    parameter int IDX_W = 5
) (
    input  logic                      clk_i,
    input  logic [IDX_W-1:0]          rd_idx_i,
    output logic [TAG_W-1:0]          rd_tag_o,
    output logic [WORDS*DATA_W-1:0]   rd_line_o,
    input  logic [IDX_W-1:0]          wr_idx_i,
    input  logic [WORDS-1:0]          wr_word_en_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      wr_tag_en_i,
    input  logic [TAG_W-1:0]          wr_tag_i
);

    // No reset: the controller's valid bits decide whether contents matter.
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][WORDS];

    always_ff @(posedge clk_i) begin
        if (wr_tag_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        for (int w = 0; w < WORDS; w++) begin
            if (wr_word_en_i[w]) begin
                data_q[wr_idx_i][w] <= wr_data_i;
            end
        end
    end

    assign rd_tag_o = tag_q[rd_idx_i];

    generate
        for (genvar g = 0; g < WORDS; g++) begin : g_rd_word
            assign rd_line_o[g*DATA_W +: DATA_W] = data_q[rd_idx_i][g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/m_param_multiword_cache.sv
// ============================================================================
// Module  : m_param_multiword_cache
// Brief   : Direct-mapped, multi-word-line read cache with refill and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module m_param_multiword_cache
    import m_param_multiword_cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINES  = 32,
    parameter int WORDS  = 2
) (
    input  logic              w_clock,
    input  logic              w_rst_n,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_address,
    input  logic              w_flush,
    output logic              w_ready,
    output logic              w_rvalid,
    output logic [31:0]       w_rdata,
    output logic              w_hit,
    output logic              w_mreq,
    output logic [ADDR_W-1:0] w_maddr,
    input  logic              w_mvalid,
    input  logic [31:0]       w_mdata,
    output logic [31:0]       w_hit_cnt,
    output logic [31:0]       w_miss_cnt
);

    localparam int OFF_W  = calc_off_w(WORDS);
    localparam int IDX_W  = calc_idx_w(LINES);
    localparam int TAG_W  = calc_tag_w(ADDR_W, LINES, WORDS);
    localparam int WSEL_W = OFF_W - 2;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [WSEL_W-1:0]   beat_q, beat_d;
    logic [IDX_W-1:0]    flush_idx_q, flush_idx_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                hit_q, hit_d;
    logic                mreq_q, mreq_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;

    logic [IDX_W-1:0]        req_idx, lat_idx, rd_idx;
    logic [TAG_W-1:0]        req_tag, lat_tag, rd_tag;
    logic [WSEL_W-1:0]       req_wsel, lat_wsel;
    logic [WORDS*DATA_W-1:0] rd_line;
    logic [DATA_W-1:0]       line_words [WORDS];
    logic                    lookup_hit;
    logic [WORDS-1:0]        ram_we_word;
    logic                    ram_we_tag;
    logic                    unused_addr_bits;

    assign req_wsel = w_address[OFF_W-1:2];
    assign req_idx  = w_address[OFF_W+IDX_W-1:OFF_W];
    assign req_tag  = w_address[ADDR_W-1:OFF_W+IDX_W];
    assign lat_wsel = addr_q[OFF_W-1:2];
    assign lat_idx  = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign lat_tag  = addr_q[ADDR_W-1:OFF_W+IDX_W];

    assign unused_addr_bits = ^{w_address[1:0], addr_q[1:0]};

    // Lookups use the live address; refill and response use the latched one.
    assign rd_idx     = (state_q == ST_IDLE) ? req_idx : lat_idx;
    assign lookup_hit = valid_q[req_idx] && (rd_tag == req_tag);

    m_cache_line_ram #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_line_ram (
        .clk_i        (w_clock),
        .rd_idx_i     (rd_idx),
        .rd_tag_o     (rd_tag),
        .rd_line_o    (rd_line),
        .wr_idx_i     (lat_idx),
        .wr_word_en_i (ram_we_word),
        .wr_data_i    (w_mdata),
        .wr_tag_en_i  (ram_we_tag),
        .wr_tag_i     (lat_tag)
    );

    generate
        for (genvar g = 0; g < WORDS; g++) begin : g_unpack
            assign line_words[g] = rd_line[g*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        beat_d      = beat_q;
        flush_idx_d = flush_idx_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        hit_d       = 1'b0;
        mreq_d      = 1'b0;
        maddr_d     = maddr_q;
        ram_we_word = '0;
        ram_we_tag  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_flush) begin
                    state_d     = ST_FLUSH;
                    flush_idx_d = '0;
                end else if (w_req) begin
                    addr_d = w_address;
                    if (lookup_hit) begin
                        rvalid_d  = 1'b1;
                        hit_d     = 1'b1;
                        rdata_d   = line_words[req_wsel];
                        hit_cnt_d = sat_inc32(hit_cnt_q);
                    end else begin
                        mreq_d     = 1'b1;
                        maddr_d    = {w_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        beat_d     = '0;
                        miss_cnt_d = sat_inc32(miss_cnt_q);
                        state_d    = ST_REFILL;
                    end
                end
            end

            ST_REFILL: begin
                if (w_mvalid) begin
                    ram_we_word = {{(WORDS-1){1'b0}}, 1'b1} << beat_q;
                    beat_d      = beat_q + 1'b1;
                    if (beat_q == WSEL_W'(WORDS - 1)) begin
                        valid_d[lat_idx] = 1'b1;
                        ram_we_tag       = 1'b1;
                        beat_d           = '0;
                        rvalid_d         = 1'b1;
                        // The final beat is not in the RAM yet; bypass it.
                        rdata_d          = (lat_wsel == beat_q) ? w_mdata
                                                                : line_words[lat_wsel];
                        state_d          = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            ST_FLUSH: begin
                valid_d[flush_idx_q] = 1'b0;
                flush_idx_d          = flush_idx_q + 1'b1;
                if (flush_idx_q == IDX_W'(LINES - 1)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge w_clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            valid_q     <= '0;
            beat_q      <= '0;
            flush_idx_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            hit_q       <= 1'b0;
            mreq_q      <= 1'b0;
            maddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            beat_q      <= beat_d;
            flush_idx_q <= flush_idx_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            hit_q       <= hit_d;
            mreq_q      <= mreq_d;
            maddr_q     <= maddr_d;
        end
    end

    assign w_ready    = (state_q == ST_IDLE);
    assign w_rvalid   = rvalid_q;
    assign w_hit      = hit_q;
    assign w_rdata    = rdata_q;
    assign w_mreq     = mreq_q;
    assign w_maddr    = maddr_q;
    assign w_hit_cnt  = hit_cnt_q;
    assign w_miss_cnt = miss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_m_param_multiword_cache.sv
// ============================================================================
// Module  : tb_m_param_multiword_cache
// Brief   : Directed, scoreboarded bench for m_param_multiword_cache.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_param_multiword_cache;

    localparam int ADDR_W = 32;
    localparam int LINES  = 32;
    localparam int WORDS  = 2;

    logic              w_clock   = 1'b0;
    logic              w_rst_n   = 1'b0;
    logic              w_req     = 1'b0;
    logic [ADDR_W-1:0] w_address = '0;
    logic              w_flush   = 1'b0;
    logic              w_mvalid  = 1'b0;
    logic [31:0]       w_mdata   = '0;
    logic              w_ready, w_rvalid, w_hit, w_mreq;
    logic [31:0]       w_rdata, w_hit_cnt, w_miss_cnt;
    logic [ADDR_W-1:0] w_maddr;

    m_param_multiword_cache #(
        .ADDR_W (ADDR_W),
        .LINES  (LINES),
        .WORDS  (WORDS)
    ) dut (
        .w_clock    (w_clock),
        .w_rst_n    (w_rst_n),
        .w_req      (w_req),
        .w_address  (w_address),
        .w_flush    (w_flush),
        .w_ready    (w_ready),
        .w_rvalid   (w_rvalid),
        .w_rdata    (w_rdata),
        .w_hit      (w_hit),
        .w_mreq     (w_mreq),
        .w_maddr    (w_maddr),
        .w_mvalid   (w_mvalid),
        .w_mdata    (w_mdata),
        .w_hit_cnt  (w_hit_cnt),
        .w_miss_cnt (w_miss_cnt)
    );

    always #5 w_clock = ~w_clock;

    typedef struct {
        logic [31:0] data;
        logic        hit;
    } exp_t;

    exp_t        sb [$];
    int          checks   = 0;
    int          failures = 0;
    logic        mvld [LINES];
    logic [23:0] mtag [LINES];
    logic [31:0] hit_m  = '0;
    logic [31:0] miss_m = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Backing memory: fixed words for line 0x100, an address-derived pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (wa == 32'h0000_0100) return 32'hAAAA_0000;
        if (wa == 32'h0000_0104) return 32'hBBBB_0001;
        return {wa[15:0] ^ 16'h5A5A, wa[15:0]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mvld[i] = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_hit_cnt"}, w_hit_cnt, hit_m);
        chk({tag, "_miss_cnt"}, w_miss_cnt, miss_m);
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_unexpected_rvalid"}, {31'd0, w_rvalid}, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, w_rdata, e.data);
            chk({tag, "_hit"}, {31'd0, w_hit}, {31'd0, e.hit});
        end
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input bit gap);
        logic [4:0]  idx;
        logic [23:0] tg;
        logic [31:0] line;
        logic [31:0] held;
        bit          is_hit;
        exp_t        e;
        int          n;
        idx    = a[7:3];
        tg     = a[31:8];
        line   = {a[31:3], 3'b000};
        is_hit = mvld[idx] && (mtag[idx] == tg);
        e.data = mem_word(a);
        e.hit  = is_hit;
        sb.push_back(e);
        chk({tag, "_ready_before"}, {31'd0, w_ready}, 32'd1);
        w_req     = 1'b1;
        w_address = a;
        @(negedge w_clock);
        w_req = 1'b0;
        if (is_hit) begin
            chk({tag, "_no_mreq"}, {31'd0, w_mreq}, 32'd0);
            hit_m = sat(hit_m);
        end else begin
            chk({tag, "_mreq"}, {31'd0, w_mreq}, 32'd1);
            chk({tag, "_maddr"}, w_maddr, line);
            miss_m = sat(miss_m);
            for (int b = 0; b < WORDS; b++) begin
                if (gap && b == 1) begin
                    w_mvalid = 1'b0;
                    @(negedge w_clock);
                    chk({tag, "_no_rvalid_in_gap"}, {31'd0, w_rvalid}, 32'd0);
                end
                w_mvalid = 1'b1;
                w_mdata  = mem_word(line + 32'(b * 4));
                @(negedge w_clock);
                if (b == 0) chk({tag, "_mreq_single"}, {31'd0, w_mreq}, 32'd0);
            end
            w_mvalid = 1'b0;
            mvld[idx] = 1'b1;
            mtag[idx] = tg;
        end
        n = 0;
        while (!w_rvalid && n < 20) begin
            @(negedge w_clock);
            n++;
        end
        if (!w_rvalid) begin
            chk({tag, "_rvalid_timeout"}, {31'd0, w_rvalid}, 32'd1);
            void'(sb.pop_front());
        end else begin
            pop_and_check(tag);
            chk({tag, "_ready_at_rvalid"}, {31'd0, w_ready}, is_hit ? 32'd1 : 32'd0);
            held = w_rdata;
            @(negedge w_clock);
            chk({tag, "_rvalid_one_cycle"}, {31'd0, w_rvalid}, 32'd0);
            chk({tag, "_rdata_held"}, w_rdata, held);
            chk({tag, "_ready_after"}, {31'd0, w_ready}, 32'd1);
        end
        check_counters(tag);
    endtask

    initial begin
        int n;
        bit rv_seen;
        exp_t e;
        model_clear();

        // Reset state
        repeat (3) @(negedge w_clock);
        chk("rst_ready", {31'd0, w_ready}, 32'd1);
        chk("rst_rvalid", {31'd0, w_rvalid}, 32'd0);
        chk("rst_hit", {31'd0, w_hit}, 32'd0);
        chk("rst_mreq", {31'd0, w_mreq}, 32'd0);
        chk("rst_rdata", w_rdata, 32'd0);
        chk("rst_maddr", w_maddr, 32'd0);
        check_counters("rst");
        w_rst_n = 1'b1;
        @(negedge w_clock);

        // Cold miss, hit after fill, refill with a beat gap
        do_read("cold_miss", 32'h0000_0104, 1'b0);
        do_read("hit_fill", 32'h0000_0100, 1'b0);
        do_read("miss_gap", 32'h0000_0208, 1'b1);
        do_read("hit_other", 32'h0000_020C, 1'b0);

        // Conflict miss replaces line 0, then the old tag misses again
        do_read("conflict", 32'h0000_1100, 1'b0);
        do_read("hit_conf", 32'h0000_1104, 1'b0);
        do_read("remiss", 32'h0000_0100, 1'b1);

        // Back-to-back hits: one result per cycle
        e.data = 32'hAAAA_0000; e.hit = 1'b1; sb.push_back(e);
        e.data = 32'hBBBB_0001; e.hit = 1'b1; sb.push_back(e);
        w_req = 1'b1; w_address = 32'h0000_0100;
        @(negedge w_clock);
        chk("b2b_rvalid0", {31'd0, w_rvalid}, 32'd1);
        pop_and_check("b2b0");
        w_address = 32'h0000_0104;
        @(negedge w_clock);
        w_req = 1'b0;
        chk("b2b_rvalid1", {31'd0, w_rvalid}, 32'd1);
        pop_and_check("b2b1");
        hit_m = sat(sat(hit_m));
        @(negedge w_clock);
        check_counters("b2b");

        // Flush with a simultaneous request: flush wins, 32 busy cycles
        w_flush = 1'b1; w_req = 1'b1; w_address = 32'h0000_0100;
        @(negedge w_clock);
        w_flush = 1'b0; w_req = 1'b0;
        n = 0; rv_seen = 1'b0;
        while (!w_ready && n < 200) begin
            if (w_rvalid || w_mreq) rv_seen = 1'b1;
            @(negedge w_clock);
            n++;
        end
        chk("flush_busy_cycles", 32'(n), 32'd32);
        chk("flush_no_output", {31'd0, rv_seen}, 32'd0);
        model_clear();
        check_counters("flush");
        do_read("post_flush0", 32'h0000_0100, 1'b0);
        do_read("post_flush1", 32'h0000_0208, 1'b0);

        // Reset in the middle of a refill
        w_req = 1'b1; w_address = 32'h0000_0300;
        @(negedge w_clock);
        w_req = 1'b0;
        chk("mid_mreq", {31'd0, w_mreq}, 32'd1);
        w_mvalid = 1'b1; w_mdata = mem_word(32'h0000_0300);
        @(negedge w_clock);
        #2 w_rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, w_ready}, 32'd1);
        chk("mid_rst_maddr", w_maddr, 32'd0);
        chk("mid_rst_rdata", w_rdata, 32'd0);
        model_clear();
        hit_m = '0; miss_m = '0;
        check_counters("mid_rst");
        @(negedge w_clock);
        w_rst_n = 1'b1;
        rv_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_mdata = 32'hDEAD_0000 + 32'(i);
            @(negedge w_clock);
            if (!w_ready || w_rvalid || w_mreq) rv_seen = 1'b1;
        end
        w_mvalid = 1'b0;
        chk("stray_beats_ignored", {31'd0, rv_seen}, 32'd0);
        do_read("after_rst", 32'h0000_0300, 1'b0);

        // Hit counter saturation
        force dut.hit_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt_q;
        hit_m = 32'hFFFF_FFFE;
        check_counters("forced");
        do_read("sat_hit0", 32'h0000_0300, 1'b0);
        do_read("sat_hit1", 32'h0000_0304, 1'b0);
        do_read("sat_hit2", 32'h0000_0300, 1'b0);
        chk("sat_final", w_hit_cnt, 32'hFFFF_FFFF);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
